se_requester: RTL and testbench

//  Initiator side of the hash_2_bucket search-engine interface (se_*/aging_*).
//  Per ingress frame header: learns the SA against the ingress port, then looks up the DA.

---
 rtl/se_pkg.sv | 20 ++
 rtl/se_aging_timer.sv | 33 +++
 rtl/se_requester.sv | 169 ++++++++++++++++
 tb/tb_se_requester.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/se_pkg.sv
// Shared widths, FSM state type and MAC-to-bucket hash fold for the
// search-engine requester.
package se_pkg;
  localparam int MAC_W  = 48;
  localparam int HASH_W = 10;
  localparam int PMAP_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AGE,
    ST_LEARN,
    ST_GAP,
    ST_SEARCH,
    ST_RESULT
  } se_state_t;

  function automatic logic [HASH_W-1:0] se_hash_fold(input logic [MAC_W-1:0] mac);
    return mac[9:0] ^ mac[19:10] ^ mac[29:20] ^ mac[39:30] ^ {2'b00, mac[47:40]};
  endfunction
endpackage

// File: rtl/se_aging_timer.sv
// Free-running aging period counter with a sticky pending flag; repeated
// expiries while a sweep is pending collapse into a single request.
module se_aging_timer
  import se_pkg::*;
#(
  parameter int AGING_PERIOD = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic aging_due
);
  localparam int CNT_W = $clog2(AGING_PERIOD);

  logic [CNT_W-1:0] count;
  logic             pend;
  logic             expire;

  assign expire = (count == CNT_W'(AGING_PERIOD - 1));
  // The expiring cycle already counts as due so a coincident header loses to aging.
  assign aging_due = pend | expire;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      pend  <= 1'b0;
    end else begin
      count <= expire ? '0 : count + 1'b1;
      if (expire) pend <= 1'b1;
      else if (clear) pend <= 1'b0;
    end
  end
endmodule

// File: rtl/se_requester.sv
// Search-engine initiator: learns the SA, looks up the DA, returns a filtered
// forwarding portmap and arbitrates the periodic aging sweep.
module se_requester
  import se_pkg::*;
#(
  parameter int PORTS        = 16,
  parameter int AGING_PERIOD = 100000,
  parameter int SE_TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hdr_valid,
  output logic              hdr_ready,
  input  logic [MAC_W-1:0]  hdr_da,
  input  logic [MAC_W-1:0]  hdr_sa,
  input  logic [3:0]        hdr_port,
  output logic              fwd_valid,
  input  logic              fwd_ready,
  output logic [PMAP_W-1:0] fwd_portmap,
  output logic              fwd_hit,
  output logic              se_source,
  output logic [MAC_W-1:0]  se_mac,
  output logic [PMAP_W-1:0] se_portmap,
  output logic [HASH_W-1:0] se_hash,
  output logic              se_req,
  input  logic              se_ack,
  input  logic              se_nak,
  input  logic [PMAP_W-1:0] se_result,
  output logic              aging_req,
  input  logic              aging_ack,
  output logic [15:0]       learn_fail_cnt
);
  localparam int TMO_W = $clog2(SE_TIMEOUT + 1);
  localparam logic [PMAP_W-1:0] ALL_PORTS = PMAP_W'((64'd1 << PORTS) - 64'd1);

  function automatic logic [PMAP_W-1:0] port_bit(input logic [3:0] p);
    return PMAP_W'(1) << p;
  endfunction

  se_state_t        state;
  logic [MAC_W-1:0] da_q;
  logic [3:0]       port_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic             ready_q;
  logic             aging_due;
  logic             aging_clear;
  logic             accept;
  logic             timeout;
  logic             req_done;
  logic             req_hit;
  logic             enter_search;
  logic [MAC_W-1:0] s_da;
  logic [3:0]       s_port;

  se_aging_timer #(
    .AGING_PERIOD(AGING_PERIOD)
  ) u_aging (
    .clk      (clk),
    .rst      (rst),
    .clear    (aging_clear),
    .aging_due(aging_due)
  );

  assign hdr_ready   = ready_q & ~aging_due & (state == ST_IDLE);
  assign accept      = hdr_valid & hdr_ready;
  assign aging_clear = (state == ST_AGE) & aging_ack;
  assign timeout     = (tmo_cnt == TMO_W'(SE_TIMEOUT - 1));
  assign req_done    = se_ack | se_nak | timeout;
  assign req_hit     = se_ack & ~se_nak;

  // A search starts either straight from the accepted header (group SA) or after the gap.
  assign s_da         = (state == ST_IDLE) ? hdr_da : da_q;
  assign s_port       = (state == ST_IDLE) ? hdr_port : port_q;
  assign enter_search = (state == ST_GAP) | ((state == ST_IDLE) & accept & hdr_sa[40]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      ready_q        <= 1'b0;
      se_req         <= 1'b0;
      se_source      <= 1'b0;
      se_mac         <= '0;
      se_portmap     <= '0;
      se_hash        <= '0;
      aging_req      <= 1'b0;
      fwd_valid      <= 1'b0;
      fwd_portmap    <= '0;
      fwd_hit        <= 1'b0;
      learn_fail_cnt <= '0;
      tmo_cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (aging_due) begin
            ready_q   <= 1'b0;
            aging_req <= 1'b1;
            state     <= ST_AGE;
          end else if (accept) begin
            ready_q <= 1'b0;
            da_q    <= hdr_da;
            port_q  <= hdr_port;
            if (!hdr_sa[40]) begin
              state      <= ST_LEARN;
              se_req     <= 1'b1;
              se_source  <= 1'b1;
              se_mac     <= hdr_sa;
              se_hash    <= se_hash_fold(hdr_sa);
              se_portmap <= port_bit(hdr_port);
              tmo_cnt    <= '0;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_AGE: begin
          if (aging_ack) begin
            aging_req <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_LEARN: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (req_done) begin
            se_req <= 1'b0;
            state  <= ST_GAP;
            if (!req_hit && learn_fail_cnt != 16'hFFFF)
              learn_fail_cnt <= learn_fail_cnt + 16'd1;
          end
        end
        ST_GAP: begin
        end
        ST_SEARCH: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (req_done) begin
            se_req      <= 1'b0;
            fwd_valid   <= 1'b1;
            fwd_hit     <= req_hit;
            fwd_portmap <= (req_hit ? se_result : ALL_PORTS) & ~port_bit(port_q);
            state       <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (fwd_ready) begin
            fwd_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (enter_search) begin
        if (s_da[40]) begin
          state       <= ST_RESULT;
          fwd_valid   <= 1'b1;
          fwd_hit     <= 1'b0;
          fwd_portmap <= ALL_PORTS & ~port_bit(s_port);
        end else begin
          state      <= ST_SEARCH;
          se_req     <= 1'b1;
          se_source  <= 1'b0;
          se_mac     <= s_da;
          se_hash    <= se_hash_fold(s_da);
          se_portmap <= '0;
          tmo_cnt    <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_se_requester.sv
// Bench for se_requester: scripted and random frames against a table/aging
// responder, with expectations from a frame-level reference model.
module tb_se_requester;
  localparam int M_ACK = 0, M_NAK = 1, M_BOTH = 2, M_NONE = 3;

  logic        clk, rst;
  logic        hdr_valid, hdr_ready, fwd_valid, fwd_ready, fwd_hit;
  logic [47:0] hdr_da, hdr_sa, se_mac;
  logic [3:0]  hdr_port;
  logic [15:0] fwd_portmap, se_portmap, se_result, learn_fail_cnt;
  logic        se_source, se_req, se_ack, se_nak, aging_req, aging_ack;
  logic [9:0]  se_hash;

  se_requester #(.PORTS(16), .AGING_PERIOD(50), .SE_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .hdr_da(hdr_da), .hdr_sa(hdr_sa), .hdr_port(hdr_port),
    .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_portmap(fwd_portmap), .fwd_hit(fwd_hit),
    .se_source(se_source), .se_mac(se_mac), .se_portmap(se_portmap), .se_hash(se_hash),
    .se_req(se_req), .se_ack(se_ack), .se_nak(se_nak), .se_result(se_result),
    .aging_req(aging_req), .aging_ack(aging_ack), .learn_fail_cnt(learn_fail_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0, bad = 0;

  // responder configuration (written by tests) and observations (written by responder)
  int lmode = M_ACK, smode = M_ACK, resp_delay = 0;
  logic [15:0] sres = 16'h0;
  logic aging_auto = 1'b1;
  int learn_cnt = 0, search_cnt = 0, unstable = 0, age_rises = 0;
  int req_len = 0, gap_len = 100, last_gap = 0;
  logic req_prev = 1'b0, aging_prev = 1'b0;
  logic [15:0] cap_l_pmap;
  logic [9:0]  cap_l_hash, cap_s_hash;
  logic [47:0] cap_l_mac, cap_s_mac;
  logic        cur_src;
  logic [47:0] cur_mac;
  logic [9:0]  cur_hash;
  logic [15:0] cur_pmap;

  initial begin
    int mode;
    se_ack = 1'b0; se_nak = 1'b0; aging_ack = 1'b0; se_result = 16'h0;
    forever begin
      @(posedge clk); #1;
      se_ack = 1'b0; se_nak = 1'b0; aging_ack = 1'b0;
      se_result = 16'($urandom);
      if (se_req) begin
        if (!req_prev) begin
          req_len = 0;
          last_gap = gap_len;
          cur_src = se_source; cur_mac = se_mac; cur_hash = se_hash; cur_pmap = se_portmap;
          if (se_source) begin
            learn_cnt++; cap_l_pmap = se_portmap; cap_l_hash = se_hash; cap_l_mac = se_mac;
          end else begin
            search_cnt++; cap_s_hash = se_hash; cap_s_mac = se_mac;
          end
        end else if (se_source !== cur_src || se_mac !== cur_mac || se_hash !== cur_hash ||
                     se_portmap !== cur_pmap) begin
          unstable++;
        end
        req_len++;
        gap_len = 0;
        mode = se_source ? lmode : smode;
        if (req_len == resp_delay + 1) begin
          case (mode)
            M_ACK:  begin se_ack = 1'b1; se_result = sres; end
            M_NAK:  se_nak = 1'b1;
            M_BOTH: begin se_ack = 1'b1; se_nak = 1'b1; se_result = sres; end
            default: ;
          endcase
        end
      end else begin
        gap_len++;
      end
      req_prev = se_req;
      if (aging_req && !aging_prev) age_rises++;
      if (aging_req && aging_auto) aging_ack = 1'b1;
      aging_prev = aging_req;
    end
  end

  // reference model state
  logic [15:0] model_fail = 16'h0;
  logic [15:0] exp_pm;
  logic        exp_hit;
  int          exp_learn, exp_search;

  function automatic logic [9:0] ref_fold(input logic [47:0] m);
    logic [47:0] t = m;
    logic [9:0]  h = '0;
    for (int i = 0; i < 5; i++) begin
      h ^= t[9:0];
      t >>= 10;
    end
    return h;
  endfunction

  task automatic model_frame(input logic [47:0] da, input logic [47:0] sa, input logic [3:0] port,
                             input int lm, input int sm, input logic [15:0] res);
    logic [15:0] pbit;
    pbit = 16'd1 << port;
    exp_learn  = sa[40] ? 0 : 1;
    exp_search = da[40] ? 0 : 1;
    if (!sa[40] && lm != M_ACK && model_fail != 16'hFFFF) model_fail = model_fail + 16'd1;
    if (!da[40] && sm == M_ACK) begin
      exp_pm = res & ~pbit; exp_hit = 1'b1;
    end else begin
      exp_pm = 16'hFFFF & ~pbit; exp_hit = 1'b0;
    end
  endtask

  // frame driver observations
  logic        obs_ok, obs_stable, obs_after_v, obs_after_req, obs_hit;
  logic [15:0] obs_pm;
  int          obs_l, obs_s;

  task automatic run_frame(input logic [47:0] da, input logic [47:0] sa, input logic [3:0] port,
                           input int lm, input int sm, input logic [15:0] res, input int rdly);
    int n, base_l, base_s;
    lmode = lm; smode = sm; sres = res;
    base_l = learn_cnt; base_s = search_cnt;
    obs_ok = 1'b1; obs_stable = 1'b1;
    hdr_da = da; hdr_sa = sa; hdr_port = port; hdr_valid = 1'b1;
    n = 0;
    while (!hdr_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!hdr_ready) obs_ok = 1'b0;
    else begin @(posedge clk); #1; end
    hdr_valid = 1'b0;
    n = 0;
    while (!fwd_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (!fwd_valid) obs_ok = 1'b0;
    obs_pm = fwd_portmap; obs_hit = fwd_hit;
    repeat (rdly) begin
      @(posedge clk); #1;
      if (fwd_valid !== 1'b1 || fwd_portmap !== obs_pm || fwd_hit !== obs_hit) obs_stable = 1'b0;
    end
    fwd_ready = 1'b1;
    @(posedge clk); #1;
    fwd_ready = 1'b0;
    obs_after_v = fwd_valid; obs_after_req = se_req;
    obs_l = learn_cnt - base_l; obs_s = search_cnt - base_s;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({hdr_ready, fwd_valid, fwd_portmap, fwd_hit, se_source, se_mac, se_portmap, se_hash,
         se_req, aging_req, learn_fail_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b fv=%b pm=%h req=%b age=%b cnt=%h want all zero",
               hdr_ready, fwd_valid, fwd_portmap, se_req, aging_req, learn_fail_cnt);
    end
    rst = 1'b0;
    model_fail = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (hdr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", hdr_ready); end
  endtask

  task automatic test_learn_search();
    model_frame(48'hd0d1d2d3d4d5, 48'he0e1e2e3e4e5, 4'd1, M_ACK, M_ACK, 16'h0004);
    run_frame(48'hd0d1d2d3d4d5, 48'he0e1e2e3e4e5, 4'd1, M_ACK, M_ACK, 16'h0004, 0);
    total++; if (obs_ok !== 1'b1) begin bad++; $display("FAIL ls_handshake: got %b want 1", obs_ok); end
    total++; if (cap_l_pmap !== 16'h0002) begin bad++; $display("FAIL ls_learn_pmap: got %h want 0002", cap_l_pmap); end
    total++; if (cap_l_mac !== 48'he0e1e2e3e4e5) begin bad++; $display("FAIL ls_learn_mac: got %h want e0e1e2e3e4e5", cap_l_mac); end
    total++; if (cap_l_hash !== ref_fold(48'he0e1e2e3e4e5)) begin bad++; $display("FAIL ls_learn_hash: got %h want %h", cap_l_hash, ref_fold(48'he0e1e2e3e4e5)); end
    total++; if (cap_s_hash !== ref_fold(48'hd0d1d2d3d4d5)) begin bad++; $display("FAIL ls_search_hash: got %h want %h", cap_s_hash, ref_fold(48'hd0d1d2d3d4d5)); end
    total++; if (last_gap !== 1) begin bad++; $display("FAIL ls_gap: got %0d want 1", last_gap); end
    total++; if (obs_pm !== 16'h0004 || obs_hit !== 1'b1) begin bad++; $display("FAIL ls_result: got %h/%b want 0004/1", obs_pm, obs_hit); end
    total++; if (obs_after_v !== 1'b0 || obs_after_req !== 1'b0) begin bad++; $display("FAIL ls_release: got fv=%b req=%b want 0/0", obs_after_v, obs_after_req); end
  endtask

  task automatic test_miss();
    model_frame(48'h0a0b0c0d0e0f, 48'h020000000033, 4'd3, M_NAK, M_NAK, 16'h1234);
    run_frame(48'h0a0b0c0d0e0f, 48'h020000000033, 4'd3, M_NAK, M_NAK, 16'h1234, 0);
    total++; if (obs_pm !== 16'hFFF7 || obs_hit !== 1'b0) begin bad++; $display("FAIL miss_result: got %h/%b want fff7/0", obs_pm, obs_hit); end
    total++; if (learn_fail_cnt !== 16'd1) begin bad++; $display("FAIL miss_failcnt: got %0d want 1", learn_fail_cnt); end
    model_frame(48'h0a0b0c0d0e11, 48'h020000000044, 4'd0, M_BOTH, M_BOTH, 16'h00F0);
    run_frame(48'h0a0b0c0d0e11, 48'h020000000044, 4'd0, M_BOTH, M_BOTH, 16'h00F0, 1);
    total++; if (obs_pm !== exp_pm || obs_hit !== exp_hit) begin bad++; $display("FAIL both_result: got %h/%b want %h/%b", obs_pm, obs_hit, exp_pm, exp_hit); end
    total++; if (learn_fail_cnt !== model_fail) begin bad++; $display("FAIL both_failcnt: got %0d want %0d", learn_fail_cnt, model_fail); end
  endtask

  task automatic test_broadcast();
    model_frame(48'hffffffffffff, 48'h001122334455, 4'd5, M_ACK, M_ACK, 16'h0F0F);
    run_frame(48'hffffffffffff, 48'h001122334455, 4'd5, M_ACK, M_ACK, 16'h0F0F, 0);
    total++; if (obs_s !== 0 || obs_l !== 1) begin bad++; $display("FAIL bc_requests: got l=%0d s=%0d want 1/0", obs_l, obs_s); end
    total++; if (obs_pm !== 16'hFFDF || obs_hit !== 1'b0) begin bad++; $display("FAIL bc_result: got %h/%b want ffdf/0", obs_pm, obs_hit); end
    // group SA skips learning; a hit filtered down to zero is still a hit
    model_frame(48'h00aabbccddee, 48'h01aabbccddee, 4'd4, M_NAK, M_ACK, 16'h0010);
    run_frame(48'h00aabbccddee, 48'h01aabbccddee, 4'd4, M_NAK, M_ACK, 16'h0010, 0);
    total++; if (obs_l !== 0 || obs_s !== 1) begin bad++; $display("FAIL gsa_requests: got l=%0d s=%0d want 0/1", obs_l, obs_s); end
    total++; if (obs_pm !== 16'h0000 || obs_hit !== 1'b1) begin bad++; $display("FAIL gsa_result: got %h/%b want 0000/1", obs_pm, obs_hit); end
    total++; if (learn_fail_cnt !== model_fail) begin bad++; $display("FAIL gsa_failcnt: got %0d want %0d", learn_fail_cnt, model_fail); end
  endtask

  task automatic test_timeout();
    model_frame(48'h123456789abc, 48'h223344556677, 4'd2, M_ACK, M_NONE, 16'h0);
    run_frame(48'h123456789abc, 48'h223344556677, 4'd2, M_ACK, M_NONE, 16'h0, 0);
    total++; if (req_len !== 8) begin bad++; $display("FAIL tmo_req_len: got %0d want 8", req_len); end
    total++; if (obs_pm !== 16'hFFFB || obs_hit !== 1'b0) begin bad++; $display("FAIL tmo_result: got %h/%b want fffb/0", obs_pm, obs_hit); end
    model_frame(48'h123456789abd, 48'h223344556678, 4'd7, M_NONE, M_ACK, 16'h0300);
    run_frame(48'h123456789abd, 48'h223344556678, 4'd7, M_NONE, M_ACK, 16'h0300, 0);
    total++; if (learn_fail_cnt !== model_fail) begin bad++; $display("FAIL tmo_failcnt: got %0d want %0d", learn_fail_cnt, model_fail); end
    total++; if (obs_pm !== 16'h0300 || obs_hit !== 1'b1) begin bad++; $display("FAIL tmo_learn_result: got %h/%b want 0300/1", obs_pm, obs_hit); end
  endtask

  task automatic test_backpressure();
    model_frame(48'h00000000beef, 48'h00000000cafe, 4'd9, M_ACK, M_ACK, 16'hA5A5);
    run_frame(48'h00000000beef, 48'h00000000cafe, 4'd9, M_ACK, M_ACK, 16'hA5A5, 10);
    total++; if (obs_stable !== 1'b1) begin bad++; $display("FAIL bp_stable: got %b want 1", obs_stable); end
    total++; if (obs_pm !== exp_pm || obs_hit !== exp_hit) begin bad++; $display("FAIL bp_result: got %h/%b want %h/%b", obs_pm, obs_hit, exp_pm, exp_hit); end
    total++; if (obs_after_v !== 1'b0) begin bad++; $display("FAIL bp_release: got %b want 0", obs_after_v); end
  endtask

  task automatic test_random();
    logic [47:0] da, sa;
    logic [3:0]  port;
    logic [15:0] res;
    int lm, sm, rd, unst0;
    unst0 = unstable;
    for (int i = 0; i < 24; i++) begin
      da = {16'($urandom), $urandom}; sa = {16'($urandom), $urandom};
      da[40] = ($urandom_range(0, 3) == 0);
      sa[40] = ($urandom_range(0, 3) == 0);
      port = 4'($urandom); res = 16'($urandom);
      lm = $urandom_range(0, 3); sm = $urandom_range(0, 3);
      rd = $urandom_range(0, 3);
      resp_delay = $urandom_range(0, 4);
      model_frame(da, sa, port, lm, sm, res);
      run_frame(da, sa, port, lm, sm, res, rd);
      total++;
      if (obs_ok !== 1'b1 || obs_pm !== exp_pm || obs_hit !== exp_hit || learn_fail_cnt !== model_fail ||
          obs_l !== exp_learn || obs_s !== exp_search) begin
        bad++;
        $display("FAIL rnd_frame%0d: got ok=%b pm=%h hit=%b cnt=%0d l=%0d s=%0d want pm=%h hit=%b cnt=%0d l=%0d s=%0d",
                 i, obs_ok, obs_pm, obs_hit, learn_fail_cnt, obs_l, obs_s, exp_pm, exp_hit, model_fail, exp_learn, exp_search);
      end
    end
    resp_delay = 0;
    total++; if (unstable !== unst0) begin bad++; $display("FAIL rnd_req_stable: got %0d changes want 0", unstable - unst0); end
  endtask

  task automatic test_reset_mid_learn();
    int n;
    lmode = M_NONE; smode = M_ACK;
    hdr_da = 48'h665544332211; hdr_sa = 48'h667788990011; hdr_port = 4'd6; hdr_valid = 1'b1;
    n = 0;
    while (!hdr_ready && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    hdr_valid = 1'b0;
    total++; if (se_req !== 1'b1 || se_source !== 1'b1) begin bad++; $display("FAIL rst_learn_started: got req=%b src=%b want 1/1", se_req, se_source); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (se_req !== 1'b0 || aging_req !== 1'b0 || fwd_valid !== 1'b0 || hdr_ready !== 1'b0) begin
      bad++; $display("FAIL rst_mid_learn: got req=%b age=%b fv=%b rdy=%b want 0/0/0/0", se_req, aging_req, fwd_valid, hdr_ready);
    end
    rst = 1'b0;
    model_fail = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (hdr_ready !== 1'b1 || learn_fail_cnt !== 16'h0) begin bad++; $display("FAIL rst_idle: got rdy=%b cnt=%0d want 1/0", hdr_ready, learn_fail_cnt); end
    model_frame(48'h665544332211, 48'h667788990011, 4'd6, M_ACK, M_ACK, 16'h00C0);
    run_frame(48'h665544332211, 48'h667788990011, 4'd6, M_ACK, M_ACK, 16'h00C0, 0);
    total++; if (obs_pm !== 16'h0080 || obs_hit !== 1'b1) begin bad++; $display("FAIL rst_after_frame: got %h/%b want 0080/1", obs_pm, obs_hit); end
  endtask

  task automatic test_aging();
    int base_age;
    logic ready_seen, age_dropped;
    aging_auto = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_fail = 16'h0;
    base_age = age_rises;
    // 49 edges after reset the timer sits in its expiring cycle
    repeat (49) @(posedge clk);
    #1;
    total++; if (hdr_ready !== 1'b0) begin bad++; $display("FAIL age_masks_ready: got %b want 0", hdr_ready); end
    hdr_da = 48'h3a3b3c3d3e3f; hdr_sa = 48'h4a4b4c4d4e4f; hdr_port = 4'd8; hdr_valid = 1'b1;
    @(posedge clk); #1;
    total++; if (aging_req !== 1'b1) begin bad++; $display("FAIL age_first: got %b want 1", aging_req); end
    ready_seen = 1'b0; age_dropped = 1'b0;
    repeat (120) begin
      @(posedge clk); #1;
      if (hdr_ready) ready_seen = 1'b1;
      if (!aging_req) age_dropped = 1'b1;
    end
    total++; if (ready_seen !== 1'b0 || age_dropped !== 1'b0) begin bad++; $display("FAIL age_hold: got rdy_seen=%b dropped=%b want 0/0", ready_seen, age_dropped); end
    aging_auto = 1'b1;
    model_frame(48'h3a3b3c3d3e3f, 48'h4a4b4c4d4e4f, 4'd8, M_ACK, M_ACK, 16'h0101);
    run_frame(48'h3a3b3c3d3e3f, 48'h4a4b4c4d4e4f, 4'd8, M_ACK, M_ACK, 16'h0101, 0);
    total++; if (age_rises - base_age !== 1) begin bad++; $display("FAIL age_collapse: got %0d requests want 1", age_rises - base_age); end
    total++; if (obs_ok !== 1'b1 || obs_pm !== 16'h0001 || obs_hit !== 1'b1) begin bad++; $display("FAIL age_frame: got ok=%b %h/%b want 1 0001/1", obs_ok, obs_pm, obs_hit); end
  endtask

  initial begin
    rst = 1'b1; hdr_valid = 1'b0; fwd_ready = 1'b0;
    hdr_da = '0; hdr_sa = '0; hdr_port = '0;
    test_reset();
    test_learn_search();
    test_miss();
    test_broadcast();
    test_timeout();
    test_backpressure();
    test_random();
    test_reset_mid_learn();
    test_aging();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
